// File: rtl/cache_refill_arbiter.sv
// Arbitrates one memory port between ICache and DCache miss handlers, running
// optional dirty write-back bursts followed by line refill bursts.
module cache_refill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic             ic_miss,
  input  logic [31:0]      ic_addr,
  input  logic             dc_miss,
  input  logic             dc_dirty,
  input  logic [31:0]      dc_addr,
  input  logic [31:0]      dc_victim_addr,
  input  logic [31:0]      dc_wdata,
  output logic [IDX_W-1:0] wb_idx,
  output logic             ic_done,
  output logic             dc_done,
  output logic             refill_we,
  output logic             refill_sel,
  output logic [IDX_W-1:0] refill_idx,
  output logic [31:0]      refill_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
);

  localparam int BASE_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_sel, w_sel_nxt;
  logic              r_last, w_last_nxt;
  logic [BASE_W-1:0] r_base, w_base_nxt;
  logic              w_last_word;
  logic              w_grant_d;
  logic              w_unused_offsets;

  // Offset bits of the incoming addresses never reach the memory port.
  assign w_unused_offsets = ^{ic_addr[IDX_W+1:0], dc_addr[IDX_W+1:0],
                              dc_victim_addr[IDX_W+1:0]};

  assign w_last_word = (r_idx == IDX_W'(LINE_WORDS - 1));
  // D wins when alone, or on a conflict when I held the previous grant.
  assign w_grant_d   = dc_miss & (~ic_miss | ~r_last);

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    r_base <= w_base_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_base_nxt  = r_base;
    wb_idx      = '0;
    ic_done     = 1'b0;
    dc_done     = 1'b0;
    refill_we   = 1'b0;
    refill_sel  = 1'b0;
    refill_idx  = '0;
    refill_data = mem_rdata;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (r_state)
      S_IDLE: begin
        if (ic_miss || dc_miss) begin
          w_sel_nxt  = w_grant_d;
          w_last_nxt = w_grant_d;
          w_idx_nxt  = '0;
          if (w_grant_d && dc_dirty) begin
            w_base_nxt  = dc_victim_addr[31:IDX_W+2];
            w_state_nxt = S_WB;
          end else begin
            w_base_nxt  = w_grant_d ? dc_addr[31:IDX_W+2] : ic_addr[31:IDX_W+2];
            w_state_nxt = S_RD;
          end
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_base, r_idx, 2'b00};
        wb_idx    = r_idx;
        mem_wdata = dc_wdata;
        if (mem_ack) begin
          w_idx_nxt = r_idx + IDX_W'(1);
          if (w_last_word) begin
            w_idx_nxt   = '0;
            w_base_nxt  = dc_addr[31:IDX_W+2];
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        mem_req    = 1'b1;
        mem_addr   = {r_base, r_idx, 2'b00};
        refill_we  = mem_ack;
        refill_sel = r_sel;
        refill_idx = r_idx;
        if (mem_ack) begin
          w_idx_nxt = r_idx + IDX_W'(1);
          if (w_last_word) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ic_done     = ~r_sel;
        dc_done     = r_sel;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
